// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Brief    : Round-robin sharing of one external multiplier among NUM_REQ
//            valid/ready requesters; products are returned tagged with an ID.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = 36,
    parameter int B_WIDTH     = 36,
    parameter int Y_WIDTH     = A_WIDTH + B_WIDTH,
    parameter int MUL_LATENCY = 1,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [Y_WIDTH-1:0]         resp_out,
    output logic [A_WIDTH-1:0]         mul_a,
    output logic [B_WIDTH-1:0]         mul_b,
    input  logic [Y_WIDTH-1:0]         mul_out,
    output logic                       busy
);

    localparam int c_CNT_W = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_rr;
    logic [ID_W-1:0]      r_id;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [A_WIDTH-1:0]   r_mul_a;
    logic [B_WIDTH-1:0]   r_mul_b;
    logic [Y_WIDTH-1:0]   r_resp_out;
    logic [ID_W-1:0]      r_resp_id;
    logic                 r_resp_valid;
    logic                 r_busy;

    logic [ID_W-1:0]      w_idx [NUM_REQ];
    logic [A_WIDTH-1:0]   w_a   [NUM_REQ];
    logic [B_WIDTH-1:0]   w_b   [NUM_REQ];
    logic                 w_found;
    logic [ID_W-1:0]      w_gnt;
    logic [ID_W-1:0]      w_next_rr;

    // w_idx[k] is the requester examined k-th when searching upward from r_rr.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
            logic [ID_W:0] w_sum;
            logic [ID_W:0] w_wrap;
            assign w_sum    = {1'b0, r_rr} + (ID_W+1)'(g);
            assign w_wrap   = w_sum - (ID_W+1)'(NUM_REQ);
            assign w_idx[g] = (w_sum >= (ID_W+1)'(NUM_REQ)) ? w_wrap[ID_W-1:0]
                                                             : w_sum[ID_W-1:0];
            assign w_a[g]   = req_a[g*A_WIDTH +: A_WIDTH];
            assign w_b[g]   = req_b[g*B_WIDTH +: B_WIDTH];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[w_idx[k]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[k];
            end
        end
    end

    assign w_next_rr = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_resp_out   <= '0;
            r_resp_id    <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_mul_a <= w_a[w_gnt];
                        r_mul_b <= w_b[w_gnt];
                        r_id    <= w_gnt;
                        r_rr    <= w_next_rr;
                        r_cnt   <= c_CNT_W'(MUL_LATENCY);
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Last wait cycle: the multiplier output now reflects r_mul_a/r_mul_b.
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_resp_out   <= mul_out;
                        r_resp_id    <= r_id;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign resp_out   = r_resp_out;
    assign resp_id    = r_resp_id;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Brief    : Directed bench with a cycle-timed reference model for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int AW  = 36;
    localparam int BW  = 36;
    localparam int YW  = 72;
    localparam int IDW = 2;
    localparam int L1  = 1;
    localparam int L2  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            resp_valid, resp_ready, busy;
    logic [IDW-1:0]  resp_id;
    logic [YW-1:0]   resp_out, mul_out;
    logic [AW-1:0]   mul_a;
    logic [BW-1:0]   mul_b;
    logic [AW-1:0]   op_a [N];
    logic [BW-1:0]   op_b [N];

    logic [N-1:0]    req_valid2, req_ready2;
    logic [N*AW-1:0] req_a2;
    logic [N*BW-1:0] req_b2;
    logic            resp_valid2, resp_ready2, busy2;
    logic [IDW-1:0]  resp_id2;
    logic [YW-1:0]   resp_out2, mul_out2;
    logic [AW-1:0]   mul_a2;
    logic [BW-1:0]   mul_b2;
    logic [AW-1:0]   op2_a [N];
    logic [BW-1:0]   op2_b [N];
    logic            glitch;

    generate
        for (genvar g = 0; g < N; g++) begin : g_pack
            assign req_a[g*AW +: AW]  = op_a[g];
            assign req_b[g*BW +: BW]  = op_b[g];
            assign req_a2[g*AW +: AW] = op2_a[g];
            assign req_b2[g*BW +: BW] = op2_b[g];
        end
    endgenerate

    assign mul_out  = mul_a * mul_b;
    // Second multiplier only shows the true product in the sampling cycle.
    assign mul_out2 = glitch ? 72'h0000_0000_0000_0BAD : mul_a2 * mul_b2;

    mult_share_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .MUL_LATENCY(L1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_out(resp_out), .mul_a(mul_a), .mul_b(mul_b),
        .mul_out(mul_out), .busy(busy)
    );

    mult_share_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .MUL_LATENCY(L2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_id(resp_id2), .resp_out(resp_out2), .mul_a(mul_a2), .mul_b(mul_b2),
        .mul_out(mul_out2), .busy(busy2)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation owes a response L1+1 cycles later,
    // held until handshaken; only an idle arbiter may grant.
    int            cyc    = 0;
    bit            m_idle = 1'b1;
    int            m_due  = 0;
    int            m_rr   = 0;
    int            m_id   = 0;
    logic [YW-1:0] m_y    = '0;
    logic [AW-1:0] m_a    = '0;
    logic [BW-1:0] m_b    = '0;

    always @(negedge clk) begin : p_compare
        logic [N-1:0] exp_ready;
        int           g;
        bit           respph;
        respph    = !m_idle && (cyc >= m_due);
        g         = -1;
        exp_ready = '0;
        if (m_idle && rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, respph);
        check("busy", busy, !m_idle);
        check("mul_a", mul_a, m_a);
        check("mul_b", mul_b, m_b);
        if (respph) begin
            check("resp_out", resp_out, m_y);
            check("resp_id", resp_id, m_id);
        end
        if (!rst_n) begin
            m_idle = 1'b1;
            m_rr   = 0;
            m_a    = '0;
            m_b    = '0;
        end else if (g >= 0) begin
            m_idle = 1'b0;
            m_due  = cyc + L1 + 1;
            m_id   = g;
            m_a    = op_a[g];
            m_b    = op_b[g];
            m_y    = YW'(op_a[g]) * YW'(op_b[g]);
            m_rr   = (g + 1) % N;
        end else if (respph && resp_ready) begin
            m_idle = 1'b1;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int            gid[$], gcy[$], rcy[$];
    logic [YW-1:0] rout[$];
    int            exp_gid[5]  = '{0, 1, 2, 3, 0};
    int            exp_gcy[5]  = '{0, 3, 6, 9, 12};
    int            exp_rcy[5]  = '{2, 5, 8, 11, 14};
    logic [YW-1:0] exp_rout[5] = '{72'd10, 72'd20, 72'd30, 72'd40, 72'd10};

    initial begin
        req_valid   = '0;
        resp_ready  = 1'b1;
        req_valid2  = '0;
        resp_ready2 = 1'b1;
        glitch      = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op2_a[i] = '0; op2_b[i] = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        smp();
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_resp_out", resp_out, 72'd0);
        check("rst_resp_id", resp_id, 2'd0);
        check("rst_mul_a", mul_a, 36'd0);
        check("rst2_resp_valid", resp_valid2, 1'b0);

        // Single request: 3*5 from requester 0
        tick();
        op_a[0] = 36'd3; op_b[0] = 36'd5; req_valid = 4'b0001;
        smp(); check("t1_ready_T", req_ready, 4'b0001);
        tick(); req_valid = '0;
        smp(); check("t1_valid_T1", resp_valid, 1'b0);
        tick();
        smp(); check("t1_valid_T2", resp_valid, 1'b1);
        check("t1_out", resp_out, 72'd15);
        check("t1_id", resp_id, 2'd0);

        // All requesters valid: rotation 0,1,2,3,0, three cycles apart
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i] = AW'(i + 1); op_b[i] = 36'd10;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            smp();
            for (int k = 0; k < N; k++) begin
                if (req_ready[k]) begin gid.push_back(k); gcy.push_back(c); end
            end
            if (resp_valid) begin rout.push_back(resp_out); rcy.push_back(c); end
            tick();
        end
        req_valid = '0;
        check("t2_grants", gid.size(), 5);
        check("t2_resps", rout.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gid.size()) begin
                check("t2_grant_id", gid[i], exp_gid[i]);
                check("t2_grant_cyc", gcy[i], exp_gcy[i]);
            end
            if (i < rout.size()) begin
                check("t2_resp_out", rout[i], exp_rout[i]);
                check("t2_resp_cyc", rcy[i], exp_rcy[i]);
            end
        end

        // Back-pressure on requester 2 (pointer 1), then wraparound from pointer 3
        op_a[2] = 36'd7; op_b[2] = 36'd6; req_valid = 4'b0100; resp_ready = 1'b0;
        smp(); check("t3_ready_T", req_ready, 4'b0100);
        tick();
        smp(); check("t3_ready_T1", req_ready, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            smp();
            check("t3_hold_valid", resp_valid, 1'b1);
            check("t3_hold_out", resp_out, 72'd42);
            check("t3_hold_id", resp_id, 2'd2);
            check("t3_hold_ready", req_ready, 4'b0000);
        end
        tick(); resp_ready = 1'b1;
        smp(); check("t3_hs_ready", req_ready, 4'b0000);
        tick();
        smp(); check("t3_wrap_grant", req_ready, 4'b0100);
        tick(); req_valid = '0;
        tick();
        smp(); check("t3_wrap_out", resp_out, 72'd42);
        tick(); req_valid = 4'b1111;
        smp(); check("t3_ptr_is_3", req_ready, 4'b1000);
        tick(); req_valid = '0;
        tick();
        tick();

        // Reset while an operation is in WAIT
        op_a[1] = 36'd9; op_b[1] = 36'd9; req_valid = 4'b0010;
        smp(); check("t5_ready", req_ready, 4'b0010);
        tick(); req_valid = '0; rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp(); check("t5_no_resp", resp_valid, 1'b0);
            tick();
        end
        smp();
        check("t5_busy", busy, 1'b0);
        check("t5_resp_out", resp_out, 72'd0);
        check("t5_resp_id", resp_id, 2'd0);
        check("t5_mul_a", mul_a, 36'd0);
        check("t5_mul_b", mul_b, 36'd0);
        tick(); req_valid = 4'b1111;
        smp(); check("t5_ptr_zero", req_ready, 4'b0001);
        tick(); req_valid = '0;
        tick();
        tick();

        // Latency 3 instance: only the sampling-cycle value of mul_out is captured
        op2_a[0] = 36'hF_FFFF_FFFF; op2_b[0] = 36'd2; req_valid2 = 4'b0001; resp_ready2 = 1'b0;
        smp(); check("t4_ready", req_ready2, 4'b0001);
        tick(); req_valid2 = '0;
        smp(); check("t4_busy", busy2, 1'b1); check("t4_v_T1", resp_valid2, 1'b0);
        tick();
        smp(); check("t4_v_T2", resp_valid2, 1'b0);
        tick(); glitch = 1'b0;
        smp(); check("t4_v_T3", resp_valid2, 1'b0);
        tick(); glitch = 1'b1;
        smp();
        check("t4_v_T4", resp_valid2, 1'b1);
        check("t4_out", resp_out2, 72'h1F_FFFF_FFFE);
        check("t4_id", resp_id2, 2'd0);
        tick();
        smp(); check("t4_hold_out", resp_out2, 72'h1F_FFFF_FFFE);
        tick(); resp_ready2 = 1'b1;
        smp(); check("t4_hold_valid", resp_valid2, 1'b1);
        tick();
        smp();
        check("t4_done_valid", resp_valid2, 1'b0);
        check("t4_done_busy", busy2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one hard `multiply` black-box instance among NUM_REQ requesters.
- Each requester has a valid/ready operand port; grants are round-robin.
- The block registers the granted operands onto the multiplier inputs, waits MUL_LATENCY cycles, captures the product and returns it tagged with the requester ID.
- Sits between datapath clients and the single multiplier in the mapped design.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- A_WIDTH, 36, operand A width (matches multiplier A_WIDTH).
- B_WIDTH, 36, operand B width (matches multiplier B_WIDTH).
- Y_WIDTH, A_WIDTH+B_WIDTH, product width.
- MUL_LATENCY, 1, cycles from operand registers to sampling mul_out (>=1).
- ID_W, max(1,clog2(NUM_REQ)), derived; width of resp_id.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept strobe.
- req_a  input  NUM_REQ*A_WIDTH  packed operand A; requester i at bits [i*A_WIDTH +: A_WIDTH].
- req_b  input  NUM_REQ*B_WIDTH  packed operand B, same packing.
- resp_valid  output  1  product valid.
- resp_ready  input  1  consumer accepts product.
- resp_id  output  ID_W  index of requester owning resp_out.
- resp_out  output  Y_WIDTH  product.
- mul_a  output  A_WIDTH  to multiplier a.
- mul_b  output  B_WIDTH  to multiplier b.
- mul_out  input  Y_WIDTH  from multiplier out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; rr pointer=0.
  - mul_a, mul_b, resp_out, resp_id, resp_valid, busy all 0; req_ready all 0.
  - Any in-flight operation is dropped with no response.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first asserted index searching from rr pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle only; all other req_ready bits stay 0.
  - At the edge: mul_a<=req_a[g], mul_b<=req_b[g], id<=g, rr pointer<=(g+1) mod NUM_REQ, cnt<=MUL_LATENCY, state<=WAIT.
  - If no req_valid: remain in IDLE; pointer unchanged.
- WAIT:
  - cnt decrements each cycle.
  - In the cycle where cnt==1: resp_out<=mul_out, resp_id<=id, resp_valid<=1, state<=RESP.
  - req_ready stays 0.
- RESP:
  - resp_valid, resp_out, resp_id held stable until resp_ready==1.
  - On resp_valid&&resp_ready at an edge: resp_valid<=0, state<=IDLE.
  - No new grant in the same cycle.
- mul_a/mul_b hold their last operands outside WAIT; they are not cleared.
- Timing: accept at cycle T -> resp_valid first high at T+MUL_LATENCY+1.
  - Minimum issue interval is MUL_LATENCY+2 cycles (resp_ready tied high).
- The block does no arithmetic; mul_out passes through unchanged. Signedness is the multiplier's concern.
- A requester may drop req_valid without a handshake; the arbiter only considers the current cycle.
- NUM_REQ==1: resp_id is always 0; the pointer stays 0.
- Simultaneous requests are served in rotation: with all valid continuously, grant order is 0,1,2,3,0,…

Test Plan:
- Reset, then req_valid=4'b0001, a=3, b=5; multiplier model out=a*b; resp_ready=1 -> req_ready[0] pulses at T; resp_valid=1 at T+2 with resp_out=15, resp_id=0.
- All four requesters valid continuously, a=i+1, b=10 -> grants in order 0,1,2,3,0; resp_out 10,20,30,40,10; each issue 3 cycles apart.
- Back-pressure: resp_ready=0 for 5 cycles after resp_valid -> resp_out/resp_id stable and no req_ready asserted; resp_ready=1 -> IDLE, next grant one cycle later.
- MUL_LATENCY=3, a=36'hFFFFFFFFF, b=2 -> resp_out=72'h1FFFFFFFFE, resp_valid at T+4; a change to mul_out before the sampling cycle is not captured.
- rst_n low for one cycle while in WAIT -> no resp_valid ever appears for that op; all outputs 0; next grant starts from requester 0.
- Only requester 2 valid while pointer=3 -> wraparound grants 2; pointer becomes 3.
